// File: rtl/swc_frame_packer.sv
// -----------------------------------------------------------------------------
// swc_frame_packer
//
// Purpose:
//    Downstream stage of the 1-to-4 sample width converter. Incoming 4*DW-bit
//    words (valid-only, no backpressure) are buffered in a first-word-fall-
//    through FIFO. Once a whole frame's worth of payload is buffered and
//    enable is high, the block emits a frame on a valid/ready stream:
//       beat 0            : header {SYNC, seq}   (m_first = 1)
//       beats 1..FRAME_LEN: FIFO words           (m_last on the final one)
//    Words that arrive while the FIFO is full and nothing is popped are
//    dropped and counted.
//
// Ports:
//    clk         in   clock
//    reset_n     in   asynchronous active-low reset
//    data_in     in   4*DW  word from the width converter
//    valid_in    in   data_in valid this cycle
//    enable      in   permits new frames to start
//    clear_ovf   in   synchronous clear of overflow / ovf_count
//    m_data      out  4*DW  output stream data
//    m_valid     out  output valid
//    m_ready     in   downstream ready
//    m_first     out  marks header word
//    m_last      out  marks final payload word
//    fifo_level  out  current FIFO occupancy
//    overflow    out  sticky: at least one word dropped
//    ovf_count   out  dropped-word count, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module swc_frame_packer #(
   parameter int              DW         = 8,
   parameter int              FRAME_LEN  = 64,
   parameter int              FIFO_DEPTH = 128,
   parameter logic [2*DW-1:0] SYNC       = 16'hA55A
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [4*DW-1:0]               data_in,
   input  logic                          valid_in,
   input  logic                          enable,
   input  logic                          clear_ovf,
   output logic [4*DW-1:0]               m_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic                          m_first,
   output logic                          m_last,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic [15:0]                   ovf_count
);

   localparam int W  = 4 * DW;
   localparam int SW = 2 * DW;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   localparam logic [BW-1:0] LAST_BEAT   = BW'(FRAME_LEN - 1);
   localparam logic [LW-1:0] LEVEL_FULL  = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] LEVEL_FRAME = LW'(FRAME_LEN);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_HEADER  = 2'd1,
      S_PAYLOAD = 2'd2
   } state_t;

   // FIFO storage and pointers
   logic [W-1:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [LW-1:0]  r_level;

   // Frame state
   state_t         r_state;
   logic [SW-1:0]  r_seq;
   logic [BW-1:0]  r_beat;

   // Registered stream outputs
   logic [W-1:0]   r_m_data;
   logic           r_m_valid;
   logic           r_m_first;
   logic           r_m_last;

   // Drop accounting
   logic           r_overflow;
   logic [15:0]    r_ovf_count;

   logic           w_xfer;
   logic           w_pop;
   logic           w_full;
   logic           w_wr;
   logic           w_drop;
   logic           w_start;
   logic [AW-1:0]  w_rd_next;
   logic [BW-1:0]  w_beat_next;

   assign w_xfer      = r_m_valid & m_ready;
   // Only payload beats consume FIFO words; the header is synthesised.
   assign w_pop       = (r_state == S_PAYLOAD) & w_xfer;
   assign w_full      = (r_level == LEVEL_FULL);
   // A pop in the same cycle frees the slot the write would otherwise miss.
   assign w_wr        = valid_in & (~w_full | w_pop);
   assign w_drop      = valid_in & w_full & ~w_pop;
   assign w_start     = enable & (r_level >= LEVEL_FRAME);
   assign w_rd_next   = r_rd_ptr + AW'(1);
   assign w_beat_next = r_beat + BW'(1);

   // -------------------------------------------------------------------------
   // FIFO storage: plain write port, no reset on the array itself.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   // -------------------------------------------------------------------------
   // FIFO pointers and occupancy
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_next;
         end
         case ({w_wr, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Overflow flag and saturating drop counter; clear beats a same-cycle drop.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_overflow  <= 1'b0;
         r_ovf_count <= '0;
      end else if (clear_ovf) begin
         r_overflow  <= 1'b0;
         r_ovf_count <= '0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (r_ovf_count != 16'hFFFF) begin
            r_ovf_count <= r_ovf_count + 16'd1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Frame state machine with registered outputs.
   //
   // m_data is a registered copy of the FIFO word that is on display; the
   // word stays counted in the FIFO until its own transfer pops it. On each
   // payload transfer the register is loaded with the word one past the read
   // pointer. All FRAME_LEN payload words were buffered before the header was
   // issued, so that look-ahead slot always holds valid data and is never the
   // slot being written in the same cycle.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_seq     <= '0;
         r_beat    <= '0;
         r_m_data  <= '0;
         r_m_valid <= 1'b0;
         r_m_first <= 1'b0;
         r_m_last  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state   <= S_HEADER;
                  r_m_valid <= 1'b1;
                  r_m_first <= 1'b1;
                  r_m_last  <= 1'b0;
                  r_m_data  <= {SYNC, r_seq};
               end
            end

            S_HEADER: begin
               if (w_xfer) begin
                  r_state   <= S_PAYLOAD;
                  r_beat    <= '0;
                  r_m_first <= 1'b0;
                  r_m_last  <= (LAST_BEAT == '0);
                  r_m_data  <= r_mem[r_rd_ptr];
               end
            end

            S_PAYLOAD: begin
               if (w_xfer) begin
                  if (r_beat == LAST_BEAT) begin
                     r_state   <= S_IDLE;
                     r_seq     <= r_seq + SW'(1);
                     r_beat    <= '0;
                     r_m_valid <= 1'b0;
                     r_m_last  <= 1'b0;
                     r_m_data  <= '0;
                  end else begin
                     r_beat   <= w_beat_next;
                     r_m_last <= (w_beat_next == LAST_BEAT);
                     r_m_data <= r_mem[w_rd_next];
                  end
               end
            end

            default: begin
               r_state   <= S_IDLE;
               r_m_valid <= 1'b0;
               r_m_first <= 1'b0;
               r_m_last  <= 1'b0;
               r_m_data  <= '0;
            end
         endcase
      end
   end

   assign m_data     = r_m_data;
   assign m_valid    = r_m_valid;
   assign m_first    = r_m_first;
   assign m_last     = r_m_last;
   assign fifo_level = r_level;
   assign overflow   = r_overflow;
   assign ovf_count  = r_ovf_count;

endmodule
